pwm_gate_guard: RTL and testbench
=================================

// Module: pwm_gate_guard
// PURPOSE
//   Gate-drive protection stage between pwm_accelerator.pwm_out and the
//   H-bridge gate-driver pins of the 5-level inverter (4 complementary pairs).
//   Blocks shoot-through, enforces a minimum gate pulse width, and debounces
//   the driver desaturation trips. Latches faults and feeds the result back to
//   the pwm_accelerator fault input.
// PARAMETERS
//   N_PAIRS    4   complementary pairs; pair k = {pwm_in[2k+1] low side, pwm_in[2k] high side}
//   MIN_PULSE  25  minimum gate on/off time in clk cycles (0.5 us at 50 MHz); >=1
//   TRIP_FILT  8   consecutive synced-low samples that qualify an ext trip; >=1
// PORTS
//   clk          in   1          system clock, 50 MHz
//   rst_n        in   1          reset, synchronous, active-low
//   pwm_in       in   2*N_PAIRS  raw PWM from pwm_accelerator (already deadtimed)
//   arm          in   1          1 = request RUN; 0 = request SAFE
//   fault_clear  in   1          one-cycle pulse that clears a latched fault
//   ext_trip_n   in   N_PAIRS    driver DESAT/fault pins, asynchronous, active-low
//   gate_out     out  2*N_PAIRS  registered gate commands to the drivers
//   fault        out  1          registered; 1 while state==FAULT
//   fault_flags  out  2*N_PAIRS  sticky causes: [N-1:0] shoot-through per pair,
//                                [2N-1:N] ext trip per pair
//   state        out  2          0=SAFE 1=RUN 2=FAULT (3 unused, decodes as FAULT)
// BEHAVIOUR
//   Reset: state=SAFE; gate_out=0, fault=0, fault_flags=0; sync FFs cleared
//     to 1 (no trip); filter counters=0; pulse counters=MIN_PULSE (saturated).
//   Trip path: ext_trip_n -> 2-FF synchroniser -> per-pair counter.
//     - Counter increments while the synced value is 0; it clears when the value is 1.
//     - trip_q[k] asserts when the count reaches TRIP_FILT; the counter saturates there.
//     - Latency from pin to trip_q is 2+TRIP_FILT cycles.
//   Shoot-through: st[k] = pwm_in[2k] & pwm_in[2k+1], evaluated every cycle in any state.
//   Any detect: any_trip = |st | |trip_q.
//   FSM, evaluated at each clk edge in priority order:
//     - any_trip, from any state -> FAULT.
//     - SAFE -> RUN when arm=1 and the guard conditions hold; entering RUN loads
//       all pulse counters to MIN_PULSE, so the first edge passes immediately.
//     - RUN -> SAFE when arm=0.
//     - FAULT -> SAFE only when fault_clear=1, arm=0 and any_trip=0; otherwise
//       fault_clear is ignored.
//     - A trip and arm or fault_clear in the same cycle: the trip wins.
//   Flags: set on the same edge as the detect (st[k] -> bit k, trip_q[k] -> bit N+k).
//     - Flags accumulate while state==FAULT.
//     - All flags clear only on the FAULT->SAFE transition.
//   Gate output, per channel c with counter cnt[c] that saturates at MIN_PULSE:
//     - If state'==RUN and not any_trip and pwm_in[c]!=gate_out[c] and
//       cnt[c]==MIN_PULSE: gate_out[c] <= pwm_in[c], cnt[c] <= 1.
//     - Otherwise: gate_out[c] holds, and cnt[c] increments until it saturates.
//     - If the input toggles back before the hold expires, the short pulse is
//       stretched to MIN_PULSE. An input still different when the hold expires
//       propagates on that edge.
//     - Nominal latency pwm_in -> gate_out is 1 cycle.
//     - State'==SAFE/FAULT or any_trip: gate_out <= 0 on that edge (1-cycle
//       kill latency), overriding the pulse-width hold.
//     - Invariant: gate_out[2k] & gate_out[2k+1] is never 1.
//   fault = (state'==FAULT), registered, so it asserts on the same edge as
//     gate_out clears.
//   Reset mid-RUN: all outputs return to reset values on the next edge.
// TESTING
//   1. Reset, arm=1, pwm_in=8'h55 -> state=RUN after 1 edge; gate_out=8'h55
//      1 cycle after each input change; fault=0.
//   2. In RUN, pwm_in[0] pulses high for 5 cycles (MIN_PULSE=25) -> gate_out[0]
//      stays high for exactly 25 cycles, then low.
//   3. pwm_in=8'h03 for 1 cycle in RUN -> next edge gate_out=8'h00, fault=1,
//      state=FAULT, fault_flags=8'h01; never gate_out[0]&gate_out[1].
//   4. ext_trip_n[2]=0 for 5 cycles -> no fault. Held low for 12 cycles ->
//      fault at cycle 2+8 (+1 reg), fault_flags=8'h40.
//   5. In FAULT: pulse fault_clear with arm=1 -> stays FAULT. Then arm=0 with
//      trip still active -> stays FAULT. Trip released, arm=0, fault_clear
//      pulse -> SAFE, flags=0, fault=0.
//   6. rst_n=0 during RUN with gate_out=8'hAA -> next edge gate_out=0,
//      state=SAFE, flags=0; re-arm resumes with the first edge passing in 1 cycle.

Source files
------------

// File: rtl/pwm_gate_guard_if.sv
// rtl/pwm_gate_guard_if.sv - PWM/gate/trip signal bundle between pwm_accelerator, guard and gate drivers
interface pwm_gate_guard_if #(
  parameter int N_PAIRS = 4
);
  logic [2*N_PAIRS-1:0] pwm_in;
  logic                 arm;
  logic                 fault_clear;
  logic [N_PAIRS-1:0]   ext_trip_n;
  logic [2*N_PAIRS-1:0] gate_out;
  logic                 fault;
  logic [2*N_PAIRS-1:0] fault_flags;
  logic [1:0]           state;

  modport master (
    output pwm_in, arm, fault_clear, ext_trip_n,
    input  gate_out, fault, fault_flags, state
  );

  modport slave (
    input  pwm_in, arm, fault_clear, ext_trip_n,
    output gate_out, fault, fault_flags, state
  );
endinterface

// File: rtl/pwm_gate_guard.sv
// rtl/pwm_gate_guard.sv - shoot-through block, min gate pulse width and debounced trip latch
module pwm_gate_guard #(
  parameter int N_PAIRS   = 4,
  parameter int MIN_PULSE = 25,
  parameter int TRIP_FILT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_gate_guard_if.slave bus
);

  localparam int NCH = 2 * N_PAIRS;
  localparam int CW  = $clog2(MIN_PULSE + 1);
  localparam int TW  = $clog2(TRIP_FILT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MIN_PULSE);
  localparam logic [TW-1:0] TRIP_MAX = TW'(TRIP_FILT);

  typedef enum logic [1:0] {
    ST_SAFE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NCH-1:0]       r_gate;
  logic [NCH-1:0]       w_gate_nxt;
  logic [CW-1:0]        r_cnt      [NCH];
  logic [CW-1:0]        w_cnt_nxt  [NCH];
  logic [CW-1:0]        w_cnt_eff  [NCH];
  logic                 r_fault;
  logic [NCH-1:0]       r_flags;
  logic [NCH-1:0]       w_flags_nxt;
  logic [N_PAIRS-1:0]   r_sync1;
  logic [N_PAIRS-1:0]   r_sync2;
  logic [TW-1:0]        r_tcnt     [N_PAIRS];
  logic [N_PAIRS-1:0]   w_trip_q;
  logic [N_PAIRS-1:0]   w_st;
  logic                 w_any_trip;
  logic                 w_run_nxt;
  logic                 w_in_fault;

  // Trip pins are asynchronous; both sync stages idle at 1 (no trip).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bus.ext_trip_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_PAIRS; k++) begin
      if (!rst_n || r_sync2[k]) begin
        r_tcnt[k] <= '0;
      end else if (r_tcnt[k] != TRIP_MAX) begin
        r_tcnt[k] <= r_tcnt[k] + 1'b1;
      end
    end
  end

  always_comb begin
    w_trip_q = '0;
    w_st     = '0;
    for (int k = 0; k < N_PAIRS; k++) begin
      w_trip_q[k] = (r_tcnt[k] == TRIP_MAX);
      w_st[k]     = bus.pwm_in[2*k] & bus.pwm_in[2*k+1];
    end
  end

  assign w_any_trip = (|w_st) | (|w_trip_q);
  assign w_in_fault = (r_state != ST_SAFE) && (r_state != ST_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_SAFE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_any_trip) begin
      w_state_nxt = ST_FAULT;
    end else begin
      case (r_state)
        ST_SAFE: if (bus.arm) w_state_nxt = ST_RUN;
        ST_RUN:  if (!bus.arm) w_state_nxt = ST_SAFE;
        default: if (bus.fault_clear && !bus.arm) w_state_nxt = ST_SAFE;
      endcase
    end
  end

  assign w_run_nxt = (w_state_nxt == ST_RUN) && !w_any_trip;

  // Counters read as saturated on the entry edge so the first edge passes at once.
  // A channel may not turn on while its complement is still driven; it follows a cycle later.
  always_comb begin
    w_gate_nxt = r_gate;
    for (int c = 0; c < NCH; c++) begin
      w_cnt_eff[c] = (r_state == ST_RUN) ? r_cnt[c] : CNT_MAX;
      w_cnt_nxt[c] = (w_cnt_eff[c] == CNT_MAX) ? CNT_MAX : w_cnt_eff[c] + 1'b1;
      if (!w_run_nxt) begin
        w_gate_nxt[c] = 1'b0;
      end else if ((bus.pwm_in[c] != r_gate[c]) && (w_cnt_eff[c] == CNT_MAX) &&
                   !(bus.pwm_in[c] && r_gate[c ^ 1])) begin
        w_gate_nxt[c] = bus.pwm_in[c];
        w_cnt_nxt[c]  = CW'(1);
      end
    end
  end

  always_comb begin
    w_flags_nxt = r_flags | {w_trip_q, w_st};
    if (w_in_fault && (w_state_nxt == ST_SAFE)) begin
      w_flags_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gate  <= '0;
      r_fault <= 1'b0;
      r_flags <= '0;
      for (int c = 0; c < NCH; c++) begin
        r_cnt[c] <= CNT_MAX;
      end
    end else begin
      r_gate  <= w_gate_nxt;
      r_fault <= (w_state_nxt == ST_FAULT);
      r_flags <= w_flags_nxt;
      for (int c = 0; c < NCH; c++) begin
        r_cnt[c] <= w_cnt_nxt[c];
      end
    end
  end

  assign bus.gate_out    = r_gate;
  assign bus.fault       = r_fault;
  assign bus.fault_flags = r_flags;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_pwm_gate_guard.sv
// tb/tb_pwm_gate_guard.sv - directed self-checking bench for pwm_gate_guard
module tb_pwm_gate_guard;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   hi_cnt;

  pwm_gate_guard_if #(.N_PAIRS(4)) bus ();

  pwm_gate_guard #(
    .N_PAIRS  (4),
    .MIN_PULSE(25),
    .TRIP_FILT(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later and check the gate-pair invariant.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("no_shoot_through", 32'(bus.gate_out[2*k] & bus.gate_out[2*k+1]), 32'd0);
    end
  endtask

  initial begin
    compared         = 0;
    mismatched       = 0;
    rst_n            = 1'b0;
    bus.pwm_in       = 8'h00;
    bus.arm          = 1'b0;
    bus.fault_clear  = 1'b0;
    bus.ext_trip_n   = 4'hF;
    step();
    step();
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_gate", 32'(bus.gate_out), 32'h00);
    chk("reset_fault", 32'(bus.fault), 32'd0);
    chk("reset_flags", 32'(bus.fault_flags), 32'h00);

    // Arm and propagate 0x55 on the entry edge
    rst_n      = 1'b1;
    bus.arm    = 1'b1;
    bus.pwm_in = 8'h55;
    step();
    chk("run_state", 32'(bus.state), 32'd1);
    chk("run_gate_55", 32'(bus.gate_out), 32'h55);
    chk("run_fault", 32'(bus.fault), 32'd0);
    for (int i = 0; i < 30; i++) step();
    bus.pwm_in = 8'h15;
    step();
    chk("gate_15", 32'(bus.gate_out), 32'h15);
    bus.pwm_in = 8'h11;
    step();
    chk("gate_11", 32'(bus.gate_out), 32'h11);

    // Minimum pulse stretch on channel 0
    bus.pwm_in = 8'h10;
    step();
    chk("gate_10", 32'(bus.gate_out), 32'h10);
    for (int i = 0; i < 30; i++) step();
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      bus.pwm_in = (i < 5) ? 8'h11 : 8'h10;
      step();
      if (bus.gate_out[0]) hi_cnt++;
      if (i == 0)  chk("stretch_first", 32'(bus.gate_out[0]), 32'd1);
      if (i == 24) chk("stretch_last_hi", 32'(bus.gate_out[0]), 32'd1);
      if (i == 25) chk("stretch_released", 32'(bus.gate_out[0]), 32'd0);
    end
    chk("stretch_width", 32'(hi_cnt), 32'd25);
    chk("stretch_end_gate", 32'(bus.gate_out), 32'h10);

    // Shoot-through on pair 0
    bus.pwm_in = 8'h03;
    step();
    bus.pwm_in = 8'h00;
    chk("st_gate", 32'(bus.gate_out), 32'h00);
    chk("st_fault", 32'(bus.fault), 32'd1);
    chk("st_state", 32'(bus.state), 32'd2);
    chk("st_flags", 32'(bus.fault_flags), 32'h01);
    bus.arm         = 1'b0;
    bus.fault_clear = 1'b1;
    step();
    bus.fault_clear = 1'b0;
    chk("st_clear_state", 32'(bus.state), 32'd0);
    chk("st_clear_flags", 32'(bus.fault_flags), 32'h00);
    chk("st_clear_fault", 32'(bus.fault), 32'd0);

    // External trip filter: short glitch ignored, long low qualifies
    bus.arm = 1'b1;
    step();
    chk("rearm_state", 32'(bus.state), 32'd1);
    bus.ext_trip_n = 4'hB;
    for (int i = 0; i < 5; i++) step();
    bus.ext_trip_n = 4'hF;
    for (int i = 0; i < 10; i++) step();
    chk("glitch_fault", 32'(bus.fault), 32'd0);
    chk("glitch_state", 32'(bus.state), 32'd1);
    bus.ext_trip_n = 4'hB;
    for (int i = 0; i < 10; i++) step();
    chk("trip_not_yet", 32'(bus.fault), 32'd0);
    step();
    chk("trip_fault", 32'(bus.fault), 32'd1);
    chk("trip_state", 32'(bus.state), 32'd2);
    chk("trip_flags", 32'(bus.fault_flags), 32'h40);
    step();

    // Fault clear gating
    bus.fault_clear = 1'b1;
    step();
    bus.fault_clear = 1'b0;
    chk("clear_with_arm", 32'(bus.state), 32'd2);
    bus.arm         = 1'b0;
    bus.fault_clear = 1'b1;
    step();
    bus.fault_clear = 1'b0;
    chk("clear_trip_active", 32'(bus.state), 32'd2);
    chk("flags_held", 32'(bus.fault_flags), 32'h40);
    bus.ext_trip_n = 4'hF;
    for (int i = 0; i < 4; i++) step();
    chk("released_still_fault", 32'(bus.state), 32'd2);
    bus.fault_clear = 1'b1;
    step();
    bus.fault_clear = 1'b0;
    chk("clear_state", 32'(bus.state), 32'd0);
    chk("clear_flags", 32'(bus.fault_flags), 32'h00);
    chk("clear_fault", 32'(bus.fault), 32'd0);

    // Reset while running
    bus.arm    = 1'b1;
    bus.pwm_in = 8'hAA;
    step();
    chk("aa_gate", 32'(bus.gate_out), 32'hAA);
    rst_n = 1'b0;
    step();
    chk("rst_gate", 32'(bus.gate_out), 32'h00);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_flags", 32'(bus.fault_flags), 32'h00);
    rst_n = 1'b1;
    step();
    chk("resume_state", 32'(bus.state), 32'd1);
    chk("resume_gate", 32'(bus.gate_out), 32'hAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
